// File: rtl/regfile_bus_master.sv
// Initiator for the 4-bit phased register-file bus: accepts one command, serialises
// its read/write addresses and data as one-hot phases, and returns both read ports.
module regfile_bus_master (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_rs1,
    input  logic [3:0] cmd_rs2,
    input  logic [3:0] cmd_rd,
    input  logic [3:0] cmd_wdata,
    input  logic       cmd_wen,
    output logic [3:0] b,
    output logic [3:0] p,
    output logic       r,
    input  logic [3:0] w1,
    input  logic [3:0] w2,
    output logic       rsp_valid,
    output logic [3:0] rdata1,
    output logic [3:0] rdata2
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RR1    = 3'd1,
        ST_RR2    = 3'd2,
        ST_CAP    = 3'd3,
        ST_WR     = 3'd4,
        ST_WD     = 3'd5,
        ST_COMMIT = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] rs1_q, rs1_d;
    logic [3:0] rs2_q, rs2_d;
    logic [3:0] rd_q, rd_d;
    logic [3:0] wdata_q, wdata_d;
    logic       wen_q, wen_d;

    logic [3:0] b_q, b_d;
    logic [3:0] p_q, p_d;
    logic       r_q, r_d;
    logic       ready_q, ready_d;
    logic       rsp_q, rsp_d;
    logic [3:0] rdata1_q, rdata1_d;
    logic [3:0] rdata2_q, rdata2_d;

    // One-hot phase select driven on the bus while in a given state.
    function automatic logic [3:0] phase_sel(input state_t s);
        logic [3:0] sel;
        case (s)
            ST_RR1:  sel = 4'b0001;
            ST_RR2:  sel = 4'b0010;
            ST_WR:   sel = 4'b0100;
            ST_WD:   sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Sequencer next state; command fields are captured only on the accept edge.
    always_comb begin
        state_d = state_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d = ST_RR1;
                    rs1_d   = cmd_rs1;
                    rs2_d   = cmd_rs2;
                    rd_d    = cmd_rd;
                    wdata_d = cmd_wdata;
                    wen_d   = cmd_wen;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RR1:    state_d = ST_RR2;
            ST_RR2:    state_d = ST_CAP;
            ST_CAP: begin
                if (wen_q) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WR:     state_d = ST_WD;
            ST_WD:     state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they change with the state register.
    always_comb begin
        b_d     = 4'h0;
        p_d     = phase_sel(state_d);
        r_d     = 1'b0;
        rsp_d   = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            ST_IDLE:   ready_d = 1'b1;
            ST_RR1:    b_d     = rs1_d;
            ST_RR2:    b_d     = rs2_d;
            ST_WR:     b_d     = rd_d;
            ST_WD:     b_d     = wdata_d;
            ST_COMMIT: r_d     = 1'b1;
            ST_DONE:   rsp_d   = 1'b1;
            default:   b_d     = 4'h0;
        endcase
    end

    // Read ports are sampled at the end of CAP, ahead of any write phase.
    always_comb begin
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        if (state_q == ST_CAP) begin
            rdata1_d = w1;
            rdata2_d = w2;
        end else begin
            rdata1_d = rdata1_q;
            rdata2_d = rdata2_q;
        end
    end

    // State, latched command and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rs1_q    <= 4'h0;
            rs2_q    <= 4'h0;
            rd_q     <= 4'h0;
            wdata_q  <= 4'h0;
            wen_q    <= 1'b0;
            b_q      <= 4'h0;
            p_q      <= 4'h0;
            r_q      <= 1'b0;
            ready_q  <= 1'b0;
            rsp_q    <= 1'b0;
            rdata1_q <= 4'h0;
            rdata2_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
            b_q      <= b_d;
            p_q      <= p_d;
            r_q      <= r_d;
            ready_q  <= ready_d;
            rsp_q    <= rsp_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    assign cmd_ready = ready_q;
    assign b         = b_q;
    assign p         = p_q;
    assign r         = r_q;
    assign rsp_valid = rsp_q;
    assign rdata1    = rdata1_q;
    assign rdata2    = rdata2_q;

endmodule

// File: tb/tb_regfile_bus_master.sv
// Directed bench for regfile_bus_master with a behavioural 16x4 phased register file.
module tb_regfile_bus_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_wen;
    logic [3:0] cmd_rs1, cmd_rs2, cmd_rd, cmd_wdata;
    logic [3:0] b, p, w1, w2, rdata1, rdata2;
    logic       r, rsp_valid;

    int tests = 0;
    int fails = 0;

    regfile_bus_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
        .cmd_wdata(cmd_wdata), .cmd_wen(cmd_wen),
        .b(b), .p(p), .r(r), .w1(w1), .w2(w2),
        .rsp_valid(rsp_valid), .rdata1(rdata1), .rdata2(rdata2)
    );

    always #5 clk = ~clk;

    // Register file: phase latches capture b at the end of a selected cycle; once r
    // has been seen the write enable stays set and writes every cycle.
    logic [3:0] mem [16];
    logic [3:0] ra1_l, ra2_l, wa_l, wd_l;
    logic       we_l;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'(15 - i);
        ra1_l = 4'h0; ra2_l = 4'h0; wa_l = 4'h0; wd_l = 4'h0; we_l = 1'b0;
    end

    always @(posedge clk) begin
        if (p[0] === 1'b1) ra1_l <= b;
        if (p[1] === 1'b1) ra2_l <= b;
        if (p[2] === 1'b1) wa_l  <= b;
        if (p[3] === 1'b1) wd_l  <= b;
        if (r === 1'b1)    we_l  <= 1'b1;
        if (we_l)          mem[wa_l] <= wd_l;
    end

    assign w1 = mem[ra1_l];
    assign w2 = mem[ra2_l];

    typedef struct {
        logic [3:0] rs1, rs2, rd, wd;
        logic       wen;
        logic [3:0] e1, e2;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One command end to end: per-cycle p/b/r/rsp/ready, response data, return to idle.
    task automatic run_cmd(input vec_t v, input int id);
        int         lat;
        logic [3:0] ep, eb, bm;
        logic       er, ers;
        lat = v.wen ? 7 : 4;
        chk($sformatf("ready_before v%0d", id), 24'(cmd_ready), 24'h1);
        cmd_rs1 = v.rs1; cmd_rs2 = v.rs2; cmd_rd = v.rd; cmd_wdata = v.wd; cmd_wen = v.wen;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_rs1 = ~v.rs1; cmd_rs2 = ~v.rs2; cmd_rd = ~v.rd; cmd_wdata = ~v.wd; cmd_wen = ~v.wen;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            bm = 4'hF;
            case (c)
                1: begin ep = 4'b0001; eb = v.rs1; end
                2: begin ep = 4'b0010; eb = v.rs2; end
                3: begin ep = 4'b0000; eb = 4'h0; end
                4: begin
                    ep = v.wen ? 4'b0100 : 4'b0000;
                    eb = v.rd;
                    if (!v.wen) bm = 4'h0;
                end
                5: begin ep = 4'b1000; eb = v.wd; end
                default: begin ep = 4'b0000; eb = 4'h0; bm = 4'h0; end
            endcase
            er  = v.wen && (c == 6);
            ers = (c == lat);
            chk($sformatf("cycle v%0d c%0d {p,b,r,rsp,rdy}", id, c),
                {9'h0, p, b & bm, r, rsp_valid, cmd_ready},
                {9'h0, ep, eb & bm, er, ers, 1'b0});
        end
        chk($sformatf("rdata v%0d", id), {16'h0, rdata1, rdata2}, {16'h0, v.e1, v.e2});
        @(negedge clk);
        chk($sformatf("idle_after v%0d {p,rsp,rdy}", id),
            {18'h0, p, rsp_valid, cmd_ready}, {18'h0, 4'h0, 1'b0, 1'b1});
    endtask

    initial begin
        logic [7:0] prev_rd;
        logic [3:0] ep;

        // Register file starts as mem[i] = ~i.
        tv[0]  = '{4'h0, 4'h1, 4'h5, 4'hA, 1'b1, 4'hF, 4'hE};
        tv[1]  = '{4'h5, 4'h5, 4'h0, 4'h0, 1'b0, 4'hA, 4'hA};
        tv[2]  = '{4'h3, 4'hC, 4'h9, 4'h6, 1'b0, 4'hC, 4'h3};
        tv[3]  = '{4'h7, 4'h7, 4'h7, 4'h2, 1'b1, 4'h8, 4'h8};
        tv[4]  = '{4'h7, 4'h0, 4'h7, 4'h9, 1'b1, 4'h2, 4'hF};
        tv[5]  = '{4'h7, 4'h5, 4'h1, 4'h1, 1'b0, 4'h9, 4'hA};
        tv[6]  = '{4'hF, 4'hE, 4'h0, 4'h6, 1'b1, 4'h0, 4'h1};
        tv[7]  = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 4'h6, 4'h0};
        // After the aborted write to r3, the sticky enable copies wdata 6 into r3.
        tv[8]  = '{4'h3, 4'h4, 4'h0, 4'h0, 1'b0, 4'h6, 4'hB};
        tv[9]  = '{4'h3, 4'h2, 4'h3, 4'h1, 1'b1, 4'h6, 4'hD};
        tv[10] = '{4'h3, 4'h3, 4'h0, 4'h0, 1'b0, 4'h1, 4'h1};

        // Reset with a command pending: nothing moves, ready stays low.
        rst_n = 1'b0;
        cmd_valid = 1'b1; cmd_rs1 = 4'h3; cmd_rs2 = 4'h4; cmd_rd = 4'h5;
        cmd_wdata = 4'h6; cmd_wen = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("reset outputs %0d", k),
                {5'h0, b, p, r, rsp_valid, cmd_ready, rdata1, rdata2}, 24'h0);
        end
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("after release {rdy,p,rsp}", {18'h0, cmd_ready, p, rsp_valid}, {18'h0, 1'b1, 4'h0, 1'b0});

        for (int i = 0; i < 8; i++) run_cmd(tv[i], i);

        // cmd_valid held for 20 edges: a read-only command is accepted every 5 edges.
        prev_rd = {4'h6, 4'h0};
        cmd_rs1 = 4'h5; cmd_rs2 = 4'h7; cmd_rd = 4'h1; cmd_wdata = 4'hF; cmd_wen = 1'b0;
        cmd_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            case ((k - 1) % 5)
                0:       ep = 4'b0001;
                1:       ep = 4'b0010;
                default: ep = 4'b0000;
            endcase
            if ((k - 1) % 5 == 3) prev_rd = {4'hA, 4'h9};
            chk($sformatf("hold_valid k%0d {p,rsp,rdy,rdata}", k),
                {10'h0, p, rsp_valid, cmd_ready, rdata1, rdata2},
                {10'h0, ep, ((k - 1) % 5 == 3), ((k - 1) % 5 == 4), prev_rd});
        end
        cmd_valid = 1'b0;

        // Reset asserted while the write address phase is on the bus.
        cmd_rs1 = 4'h2; cmd_rs2 = 4'h4; cmd_rd = 4'h3; cmd_wdata = 4'hD; cmd_wen = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midreset WR phase {p,b}", {16'h0, p, b}, {16'h0, 4'b0100, 4'h3});
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset outputs", {5'h0, b, p, r, rsp_valid, cmd_ready, rdata1, rdata2}, 24'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("midreset quiet %0d {p,r,rsp,rdy}", k),
                {17'h0, p, r, rsp_valid, cmd_ready}, {17'h0, 4'h0, 1'b0, 1'b0, 1'b1});
        end

        for (int i = 8; i < 11; i++) run_cmd(tv[i], i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_bus_master.md
# regfile_bus_master

Initiator for the 4-bit phased register-file bus: accepts one register-file command through a valid/ready handshake and serialises it onto the shared bus `b`, one-hot phase select `p` and write strobe `r`. It captures the two combinational read ports `w1`/`w2` and returns them with a one-cycle response strobe. It sits between the datapath control logic and the 16x4 register file, and is the only driver of `b`/`p`/`r`.

## Interface
- Parameters: none. All widths are fixed at 4 bits to match the register-file bus.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted on a posedge with `cmd_valid & cmd_ready`.
- `cmd_rs1`  in  4  read address for port 1.
- `cmd_rs2`  in  4  read address for port 2.
- `cmd_rd`  in  4  write address.
- `cmd_wdata`  in  4  write data.
- `cmd_wen`  in  1  1 = command includes a write.
- `b`  out  4  phased bus value, registered.
- `p`  out  4  one-hot phase select, registered. `p[0]`=rr1, `p[1]`=rr2, `p[2]`=wr, `p[3]`=wdata.
- `r`  out  1  write-commit strobe, registered, one-cycle pulse.
- `w1`  in  4  register-file read port 1.
- `w2`  in  4  register-file read port 2.
- `rsp_valid`  out  1  one-cycle pulse; `rdata1`/`rdata2` are valid.
- `rdata1`  out  4  captured `w1`; held until the next capture.
- `rdata2`  out  4  captured `w2`; held until the next capture.

## Operation
- States: IDLE, RR1, RR2, CAP, WR, WD, COMMIT, DONE.
- On acceptance, all `cmd_*` fields are latched. Inputs are ignored outside the accept edge.
- RR1: `p`=0001, `b`=rs1.
- RR2: `p`=0010, `b`=rs2.
- CAP: `p`=0000, `b`=0.
  - `w1`/`w2` now reflect the new addresses.
  - Both are sampled into `rdata1`/`rdata2` at the end of CAP, before any write, so reads return pre-write values.
- Branch from CAP: `cmd_wen`=1 → WR; otherwise → DONE.
- WR: `p`=0100, `b`=rd.
- WD: `p`=1000, `b`=wdata.
- COMMIT: `p`=0000, `r`=1.
- DONE: `rsp_valid`=1 → IDLE.
- Exactly one bit of `p` is set in RR1/RR2/WR/WD. `p`=0 in every other state.
- `r` is high only in COMMIT.
- Read-only commands never drive phases 2/3, so the register file's wr/wdata latches are untouched.
- The register file's write enable, once set by `r`, stays set. The master therefore never changes wr/wdata except inside a write command.

## Timing
Cycle n = n cycles after the accept edge.
- Read-only command:
  - cycle 1 RR1, cycle 2 RR2, cycle 3 CAP, cycle 4 DONE (`rsp_valid`).
  - Next accept possible at the edge ending cycle 5.
- Write command:
  - cycles 1–3 as above, cycle 4 WR, cycle 5 WD, cycle 6 COMMIT (`r`).
  - Cycle 7 DONE: the register file's enable is live and the write lands at the end of cycle 7.
  - Next accept at the edge ending cycle 8.
- `cmd_ready`=0 from the accept edge until return to IDLE; `cmd_valid` held high meanwhile has no effect.
- Back-to-back commands: the response for command k is visible before command k+1 is accepted.
- Reset values, on any posedge with `rst_n`=0:
  - state=IDLE.
  - `b`=0, `p`=0, `r`=0, `rsp_valid`=0, `rdata1`=0, `rdata2`=0.
  - `cmd_ready`=0 while `rst_n`=0, and 1 in the first cycle after release.
- Reset mid-command: the command is discarded with no response. A partially sent phase stays latched in the register file; no recovery is attempted.
- `rst_n` low on the COMMIT edge suppresses nothing already issued, because `r` was registered in the prior cycle.

## Test plan
- Reset: hold `rst_n`=0 3 cycles with `cmd_valid`=1 → all outputs 0, `cmd_ready`=0; after release `cmd_ready`=1 and no command is accepted during reset.
- Write then read back:
  - Write rd=5, wdata=A, rs1=0, rs2=1 → `b`/`p` sequence 0/0001, 1/0010, –/0000, 5/0100, A/1000, `r` pulse in cycle 6, `rsp_valid` in cycle 7.
  - Then read rs1=5, rs2=5 → `rsp_valid` in cycle 4 with `rdata1`=`rdata2`=A.
- Read-only command: rs1=3, rs2=C, `cmd_wen`=0 → `p` never 0100/1000, `r` never 1, latency 4, `rdata` match the register-file model.
- Read-before-write in one command: rs1=rd=7, old value 2, wdata=9 → `rdata1`=2; a following read of 7 returns 9.
- Handshake: `cmd_valid` held high for 20 cycles → accepts exactly at IDLE edges; `cmd_ready` low throughout busy periods; `rdata` stable between `rsp_valid` pulses.
- Reset mid-write asserted during WR → outputs zero next cycle, no `rsp_valid`, no `r`; the next command completes normally.
